// File: rtl/kogge_stone_pipe_adder_pkg.sv
// Shared constants for the pipelined Kogge-Stone adder: default width,
// prefix-depth derivation and add/sub mode encoding.
package kogge_stone_pipe_adder_pkg;

    localparam int DEFAULT_BW = 16;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int levels_of(input int bw);
        return $clog2(bw);
    endfunction

endpackage

// File: rtl/kogge_stone_pipe_adder_if.sv
// Operand/result bundle for the pipelined adder; master drives operands and
// consumes results, slave is the adder itself.
interface kogge_stone_pipe_adder_if
    import kogge_stone_pipe_adder_pkg::*;
#(
    parameter int BW = DEFAULT_BW
);
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] sum;
    logic          cout;
    logic          ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/kogge_stone_pipe_adder_ks_prefix_level.sv
// One combinational Kogge-Stone prefix level of span D; bits below D pass
// through, the parent registers the result.
module ks_prefix_level
    import kogge_stone_pipe_adder_pkg::*;
#(
    parameter int BW = DEFAULT_BW,
    parameter int D  = 1
) (
    input  logic [BW-1:0] g,
    input  logic [BW-1:0] p,
    output logic [BW-1:0] g_nxt,
    output logic [BW-1:0] p_nxt
);
    for (genvar i = 0; i < BW; i++) begin : g_bit
        if (i >= D) begin : g_merge
            assign g_nxt[i] = g[i] | (p[i] & g[i-D]);
            assign p_nxt[i] = p[i] & p[i-D];
        end else begin : g_pass
            assign g_nxt[i] = g[i];
            assign p_nxt[i] = p[i];
        end
    end
endmodule

// File: rtl/kogge_stone_pipe_adder.sv
// Pipelined Kogge-Stone add/sub: LEVELS+2 register ranks, one beat per clock.
// A single advance enable stalls every rank together when the output is held.
module kogge_stone_pipe_adder
    import kogge_stone_pipe_adder_pkg::*;
#(
    parameter int BW = DEFAULT_BW
) (
    input  logic                    clk,
    input  logic                    rst,
    kogge_stone_pipe_adder_if.slave io
);
    localparam int LEVELS = levels_of(BW);

    logic adv;
    assign adv         = !io.out_valid | io.out_ready;
    assign io.in_ready = adv;

    // Subtraction is a + ~b + 1, so cin is replaced by a forced carry-in.
    logic [BW-1:0] b_eff;
    logic          c0_in;
    logic [BW-1:0] p_in;
    logic [BW-1:0] g_in;

    assign b_eff = (io.sub == MODE_SUB) ? ~io.b : io.b;
    assign c0_in = (io.sub == MODE_SUB) ? 1'b1 : io.cin;

    always_comb begin
        p_in    = io.a ^ b_eff;
        g_in    = io.a & b_eff;
        g_in[0] = g_in[0] | (p_in[0] & c0_in);
    end

    logic [LEVELS:0][BW-1:0] g_q;
    logic [LEVELS:0][BW-1:0] p_q;
    logic [LEVELS:0][BW-1:0] p0_q;
    logic [LEVELS:0]         c0_q;
    logic [LEVELS:0]         vld;
    logic [LEVELS:1][BW-1:0] g_c;
    logic [LEVELS:1][BW-1:0] p_c;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        ks_prefix_level #(
            .BW (BW),
            .D  (1 << (k - 1))
        ) u_lvl (
            .g     (g_q[k-1]),
            .p     (p_q[k-1]),
            .g_nxt (g_c[k]),
            .p_nxt (p_c[k])
        );
    end

    // Only the valid bits need reset; data ranks load whenever the pipe moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (adv) begin
            vld <= {vld[LEVELS-1:0], io.in_valid};
        end

        if (adv) begin
            g_q[0]  <= g_in;
            p_q[0]  <= p_in;
            p0_q[0] <= p_in;
            c0_q[0] <= c0_in;
            for (int k = 1; k <= LEVELS; k++) begin
                g_q[k]  <= g_c[k];
                p_q[k]  <= p_c[k];
                p0_q[k] <= p0_q[k-1];
                c0_q[k] <= c0_q[k-1];
            end
        end
    end

    // Group propagate of the full word is not needed once carries are known.
    logic [BW-1:0] p_final_unused;
    assign p_final_unused = p_q[LEVELS];

    logic [BW-1:0] g_f;
    logic [BW-1:0] carry;
    assign g_f   = g_q[LEVELS];
    assign carry = {g_f[BW-2:0], c0_q[LEVELS]};

    always_ff @(posedge clk) begin
        if (rst) begin
            io.out_valid <= 1'b0;
            io.sum       <= '0;
            io.cout      <= 1'b0;
            io.ovf       <= 1'b0;
        end else if (adv) begin
            io.out_valid <= vld[LEVELS];
            io.sum       <= p0_q[LEVELS] ^ carry;
            io.cout      <= g_f[BW-1];
            io.ovf       <= g_f[BW-1] ^ g_f[BW-2];
        end
    end
endmodule

// File: doc/kogge_stone_pipe_adder.md
Name: kogge_stone_pipe_adder

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor.
- Successor to the combinational 4-bit/16-bit Kogge-Stone adder.
- Width is set by BW. There is one register rank per prefix level.
- Uses a valid/ready handshake with backpressure and has an add/sub mode with a signed overflow flag.
- Sits between operand producers and result consumers in the datapath assignments; sustains one operation per clock.

Parameters:
- BW, 16, operand and sum width in bits; must be at least 2.
- LEVELS, $clog2(BW), number of prefix levels. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- a  input  BW  operand A
- b  input  BW  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0 = a+b+cin; 1 = a-b
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- sum  output  BW  result
- cout  output  1  carry-out; in sub mode, 1 = no borrow (a>=b unsigned)
- ovf  output  1  two's-complement overflow

Behaviour:
- Reset:
  - rst sampled high clears every stage valid bit.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 in the cycle after reset.
  - rst mid-operation discards all in-flight beats; nothing is emitted.
- Operand preparation:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage 0 (input register), loads on acceptance:
  - p = a ^ b_eff, g = a & b_eff.
  - Carry-in folded into bit 0: g[0] |= p[0] & c0.
  - p0 = p and c0 are kept for the sum stage.
- Stages 1..LEVELS, one register per level:
  - Level k uses span d = 2^(k-1).
  - For i >= d: G[i] = G[i] | (P[i] & G[i-d]) and P[i] = P[i] & P[i-d].
  - For i < d: G and P pass through unchanged.
  - p0 and c0 travel alongside the prefix data.
- Output stage:
  - carry[0] = c0; carry[i] = G[i-1] for i >= 1.
  - sum = p0 ^ carry.
  - cout = G[BW-1].
  - ovf = G[BW-1] ^ G[BW-2].
  - All registered.
- Latency:
  - LEVELS+2 register ranks.
  - A beat accepted at edge N is presented (out_valid=1) after edge N+LEVELS+1. For BW=16 that is N+5.
- Handshake:
  - Global advance enable: adv = !out_valid | out_ready.
  - in_ready = adv, combinational.
  - Accept when in_valid & in_ready.
  - When adv=1, every rank shifts one place; rank 0 valid = in_valid.
  - When adv=0, all ranks hold, and sum/cout/ovf hold stable while out_valid=1.
- Throughput and ordering:
  - Throughput is 1 beat per cycle while out_ready=1.
  - Bubbles are preserved, not collapsed.
  - Results leave in acceptance order.
- Simultaneous events:
  - Output consumed and input accepted in the same cycle is legal.
  - rst has priority over all other inputs.
- Wrap-around: sum is modulo 2^BW; cout carries the lost bit.
- Data registers:
  - Stage data registers may load every cycle regardless of valid; only valid bits need reset.
  - Exception: the output data registers reset to 0.

Decomposition:
- Shared package/header holds:
  - Default BW.
  - The LEVELS derivation function (clog2).
  - Mode encoding constants MODE_ADD=0, MODE_SUB=1.
- One sub-module: ks_prefix_level.
  - Parameters BW and D.
  - Inputs: G, P. Outputs: next G, next P.
  - Purely combinational.
  - Instantiated LEVELS times in a generate loop; each instance is followed by the stage register in the parent.

Test Plan:
- Reset and idle:
  - Hold rst=1 for 3 cycles, then release.
  - out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Wide add (BW=16):
  - a=16'h86A0, b=16'h86A0, cin=1, sub=0.
  - After 5 edges: sum=16'h0D41, cout=1, ovf=1.
- Subtract:
  - a=5, b=7, sub=1, cin=1 (cin ignored).
  - sum=16'hFFFE, cout=0, ovf=0.
  - Also a=7, b=5: sum=2, cout=1.
- Signed overflow:
  - a=16'h7FFF, b=16'h0001, sub=0, cin=0.
  - sum=16'h8000, cout=0, ovf=1.
- Backpressure and ordering:
  - Stream 10 beats back-to-back with operands i and i.
  - Drop out_ready for 4 cycles mid-stream.
  - in_ready=0 while stalled; outputs hold.
  - All 10 results 2i emerge in order; none lost or duplicated.
- Reset mid-flight and parameter sweep:
  - Assert rst with 3 beats in flight: no out_valid afterwards.
  - Repeat a random-vs-reference check (1000 vectors) at BW=4, 5, 16, 32; latency equals LEVELS+1 edges after acceptance.
